pim_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single PIM macro interface. It shares the PIM address, write-data and read-data bus between the RISC-V core load/store path (port 0) and the SPI debug bridge (port 1). Each access is issued as one registered PIM command, and read data is returned to the winning requester after the macro's fixed read latency. It sits in `core_top` between the core/SPI bridge and the `pim_addr_o`/`pim_wr_o`/`pim_rd_i` pins.

---
 rtl/pim_arb_pkg.sv | 16 +
 rtl/pim_arbiter_if.sv | 24 ++
 rtl/pim_arb_pick.sv | 25 ++
 rtl/pim_arbiter.sv | 157 +++++++++++++++
 tb/tb_pim_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pim_arb_pkg.sv
// Shared types and constants for the PIM macro arbiter slice.
package pim_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } pim_arb_state_e;

    localparam int unsigned PORT_CORE = 0;
    localparam int unsigned PORT_SPI  = 1;
    localparam int unsigned N_PORTS   = 2;
    localparam int unsigned LAT_W     = 4;

endpackage

// File: rtl/pim_arbiter_if.sv
// Requester-side bus of the PIM arbiter: core (port 0) and SPI bridge (port 1).
interface pim_arbiter_if #(
    parameter int unsigned XLEN = 32
) ();

    logic [1:0]           req;
    logic [1:0]           we;
    logic [1:0][XLEN-1:0] addr;
    logic [1:0][XLEN-1:0] wdata;
    logic [1:0]           gnt;
    logic [1:0]           rvalid;
    logic [XLEN-1:0]      rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/pim_arb_pick.sv
// Combinational 2-way winner picker. PIM_ARB_RR_EN selects round-robin ties,
// otherwise the core port always wins a tie.
module pim_arb_pick
    import pim_arb_pkg::*;
(
    input  logic [N_PORTS-1:0] req,
`ifdef PIM_ARB_RR_EN
    input  logic               last,
`endif
    output logic [N_PORTS-1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req[PORT_CORE] && req[PORT_SPI]) begin
`ifdef PIM_ARB_RR_EN
            // Port not granted last wins the tie.
            gnt = last ? 2'b01 : 2'b10;
`else
            gnt = 2'b01;
`endif
        end
    end

endmodule

// File: rtl/pim_arbiter.sv
// Two-port PIM macro arbiter and sequencer: one registered command per access,
// read data returned after RD_LAT cycles. PIM_ARB_RR_EN enables round-robin ties.
module pim_arbiter
    import pim_arb_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned RD_LAT = 2
) (
    input  logic            CLK,
    input  logic            RVRSTN,
    pim_arbiter_if.slave    bus,
    output logic [XLEN-1:0] PIMADDR,
    output logic [XLEN-1:0] PIMWD,
    output logic            PIMWE,
    output logic            PIMRE,
    input  logic [XLEN-1:0] PIMRD
);

    localparam logic [LAT_W-1:0] LatLoad = LAT_W'(RD_LAT - 1);
    localparam logic [LAT_W-1:0] CntOne  = LAT_W'(1);

    pim_arb_state_e     state_q, state_d;
    logic [LAT_W-1:0]   cnt_q, cnt_d;
    logic               win_q, win_d;
    logic [N_PORTS-1:0] gnt_q, gnt_d;
    logic [N_PORTS-1:0] rvalid_q, rvalid_d;
    logic [XLEN-1:0]    addr_q, addr_d;
    logic [XLEN-1:0]    wdata_q, wdata_d;
    logic [XLEN-1:0]    rdata_q, rdata_d;
    logic               we_q, we_d;
    logic               re_q, re_d;
    logic [N_PORTS-1:0] pick;
    logic               win_idx;

`ifdef PIM_ARB_RR_EN
    logic last_q, last_d;

    pim_arb_pick u_pick (
        .req  (bus.req),
        .last (last_q),
        .gnt  (pick)
    );
`else
    pim_arb_pick u_pick (
        .req (bus.req),
        .gnt (pick)
    );
`endif

    assign win_idx = pick[PORT_SPI];

    always_ff @(posedge CLK or negedge RVRSTN) begin
        if (!RVRSTN) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            win_q    <= 1'b0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
`ifdef PIM_ARB_RR_EN
            last_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            we_q     <= we_d;
            re_q     <= re_d;
`ifdef PIM_ARB_RR_EN
            last_q   <= last_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (|bus.req) state_d = StIssue;
            StIssue: begin
                if (we_q)             state_d = StIdle;
                else if (RD_LAT == 1) state_d = StResp;
                else                  state_d = StWait;
            end
            StWait:  if (cnt_q <= CntOne) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Computes next values of every registered output; strobes default low.
    always_comb begin
        cnt_d    = cnt_q;
        win_d    = win_q;
        gnt_d    = '0;
        rvalid_d = '0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        we_d     = 1'b0;
        re_d     = 1'b0;
`ifdef PIM_ARB_RR_EN
        last_d   = last_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (|bus.req) begin
                    win_d   = win_idx;
                    gnt_d   = pick;
                    addr_d  = bus.addr[win_idx];
                    wdata_d = bus.wdata[win_idx];
                    we_d    = bus.we[win_idx];
                    re_d    = ~bus.we[win_idx];
`ifdef PIM_ARB_RR_EN
                    last_d  = win_idx;
`endif
                end
            end
            StIssue: begin
                if (!we_q) begin
                    if (RD_LAT == 1) begin
                        rdata_d  = PIMRD;
                        rvalid_d = win_q ? 2'b10 : 2'b01;
                    end else begin
                        cnt_d = LatLoad;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - CntOne;
                if (cnt_q <= CntOne) begin
                    rdata_d  = PIMRD;
                    rvalid_d = win_q ? 2'b10 : 2'b01;
                end
            end
            StResp:  ;
            default: ;
        endcase
    end

    assign PIMADDR    = addr_q;
    assign PIMWD      = wdata_q;
    assign PIMWE      = we_q;
    assign PIMRE      = re_q;
    assign bus.gnt    = gnt_q;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_pim_arbiter.sv
// Directed bench for pim_arbiter: RD_LAT=2 instance with a read scoreboard plus
// an RD_LAT=1 instance. Tie expectations follow PIM_ARB_RR_EN.
module tb_pim_arbiter;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] pimaddr0, pimwd0, pimrd0, rd_pipe;
    logic        pimwe0, pimre0;
    logic [31:0] pimaddr1, pimwd1, pimrd1;
    logic        pimwe1, pimre1;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    exp_t sb_e;

    pim_arbiter_if #(.XLEN(32)) bus ();
    pim_arbiter_if #(.XLEN(32)) bus1 ();

    pim_arbiter #(.XLEN(32), .RD_LAT(2)) u_dut (
        .CLK     (clk),
        .RVRSTN  (rst_n),
        .bus     (bus),
        .PIMADDR (pimaddr0),
        .PIMWD   (pimwd0),
        .PIMWE   (pimwe0),
        .PIMRE   (pimre0),
        .PIMRD   (pimrd0)
    );

    pim_arbiter #(.XLEN(32), .RD_LAT(1)) u_dut1 (
        .CLK     (clk),
        .RVRSTN  (rst_n),
        .bus     (bus1),
        .PIMADDR (pimaddr1),
        .PIMWD   (pimwd1),
        .PIMWE   (pimwe1),
        .PIMRE   (pimre1),
        .PIMRD   (pimrd1)
    );

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro model, latency 2: data valid only in the cycle after the read strobe.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      rd_pipe <= 32'hBAD0_BAD0;
        else if (pimre0) rd_pipe <= rd_model(pimaddr0);
        else             rd_pipe <= 32'hBAD0_BAD0;
    end
    assign pimrd0 = rd_pipe;
    assign pimrd1 = pimre1 ? rd_model(pimaddr1) : 32'hBAD1_BAD1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input int max_cyc, output logic [1:0] g);
        g = 2'b00;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (bus.gnt != 2'b00) begin
                g = bus.gnt;
                break;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.rvalid != 2'b00) begin
            tests++;
            assert (exp_q.size() != 0)
            else begin
                fails++;
                $error("FAIL sb_unexpected_rvalid: observed %b expected none", bus.rvalid);
            end
            if (exp_q.size() != 0) begin
                sb_e = exp_q.pop_front();
                check("sb_port", {30'b0, bus.rvalid}, sb_e.port ? 32'd2 : 32'd1);
                check("sb_rdata", bus.rdata, sb_e.data);
            end
        end
    end

    initial begin
        #100000;
        $fatal(1, "FAIL watchdog: simulation time limit reached");
    end

    initial begin
        logic [1:0] g;
        logic       exp_port;
        int         rv_seen;

        rst_n = 1'b0;
        bus.req = '0;  bus.we = '0;  bus.addr = '0;  bus.wdata = '0;
        bus1.req = '0; bus1.we = '0; bus1.addr = '0; bus1.wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr", pimaddr0, 32'h0);
        check("rst_wd", pimwd0, 32'h0);
        check("rst_we", {31'b0, pimwe0}, 32'h0);
        check("rst_re", {31'b0, pimre0}, 32'h0);
        check("rst_gnt", {30'b0, bus.gnt}, 32'h0);
        check("rst_rvalid", {30'b0, bus.rvalid}, 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Port 0 write.
        bus.req = 2'b01; bus.we = 2'b01;
        bus.addr[0] = 32'h10; bus.wdata[0] = 32'hDEAD_BEEF;
        tick();
        check("wr_gnt", {30'b0, bus.gnt}, 32'h1);
        check("wr_we", {31'b0, pimwe0}, 32'h1);
        check("wr_re", {31'b0, pimre0}, 32'h0);
        check("wr_addr", pimaddr0, 32'h10);
        check("wr_data", pimwd0, 32'hDEAD_BEEF);
        tick();
        bus.req = 2'b00; bus.we = 2'b00;
        check("wr_we_off", {31'b0, pimwe0}, 32'h0);
        check("wr_gnt_off", {30'b0, bus.gnt}, 32'h0);
        check("wr_addr_hold", pimaddr0, 32'h10);

        // Port 1 read, RD_LAT=2.
        bus.req = 2'b10; bus.addr[1] = 32'h0;
        exp_q.push_back('{1'b1, rd_model(32'h0)});
        tick();
        check("rd_gnt", {30'b0, bus.gnt}, 32'h2);
        check("rd_re", {31'b0, pimre0}, 32'h1);
        check("rd_we", {31'b0, pimwe0}, 32'h0);
        check("rd_addr", pimaddr0, 32'h0);
        tick();
        bus.req = 2'b00;
        check("rd_wait_gnt", {30'b0, bus.gnt}, 32'h0);
        check("rd_wait_rvalid", {30'b0, bus.rvalid}, 32'h0);
        tick();
        check("rd_rvalid", {30'b0, bus.rvalid}, 32'h2);
        check("rd_rdata", bus.rdata, 32'h1234_5678);
        bus.req = 2'b01; bus.we = 2'b01;
        bus.addr[0] = 32'h20; bus.wdata[0] = 32'h0BAD_F00D;
        tick();
        check("rd_nognt", {30'b0, bus.gnt}, 32'h0);
        check("rd_rvalid_once", {30'b0, bus.rvalid}, 32'h0);
        tick();
        check("post_rd_gnt", {30'b0, bus.gnt}, 32'h1);
        check("post_rd_we", {31'b0, pimwe0}, 32'h1);
        tick();
        bus.req = 2'b00; bus.we = 2'b00;

        // Port 1 requests while port 0's read is in WAIT.
        bus.req = 2'b01; bus.addr[0] = 32'h44;
        exp_q.push_back('{1'b0, rd_model(32'h44)});
        tick();
        check("w_gnt0", {30'b0, bus.gnt}, 32'h1);
        tick();
        bus.req = 2'b10; bus.addr[1] = 32'h88;
        exp_q.push_back('{1'b1, rd_model(32'h88)});
        check("w_wait_gnt", {30'b0, bus.gnt}, 32'h0);
        tick();
        check("w_resp_gnt", {30'b0, bus.gnt}, 32'h0);
        tick();
        check("w_idle_gnt", {30'b0, bus.gnt}, 32'h0);
        tick();
        check("w_gnt1", {30'b0, bus.gnt}, 32'h2);
        check("w_addr1", pimaddr0, 32'h88);
        tick();
        bus.req = 2'b00;
        repeat (3) tick();
        check("sb_drain", 32'(exp_q.size()), 32'h0);

        // Reset while a read sits in WAIT; the read is aborted.
        bus.req = 2'b01; bus.addr[0] = 32'h300;
        tick();
        check("ab_gnt", {30'b0, bus.gnt}, 32'h1);
        tick();
        bus.req = 2'b00;
        rst_n = 1'b0;
        #1;
        check("ab_re", {31'b0, pimre0}, 32'h0);
        check("ab_we", {31'b0, pimwe0}, 32'h0);
        check("ab_addr", pimaddr0, 32'h0);
        check("ab_wd", pimwd0, 32'h0);
        check("ab_rdata", bus.rdata, 32'h0);
        check("ab_gnt_off", {30'b0, bus.gnt}, 32'h0);
        check("ab_rvalid", {30'b0, bus.rvalid}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rv_seen = 0;
        repeat (4) begin
            tick();
            if (bus.rvalid != 2'b00) rv_seen++;
        end
        check("ab_no_rvalid", 32'(rv_seen), 32'h0);

        // Both ports reading continuously.
        bus.req = 2'b11; bus.we = 2'b00;
        bus.addr[0] = 32'h100; bus.addr[1] = 32'h200;
        for (int k = 0; k < 4; k++) begin
`ifdef PIM_ARB_RR_EN
            exp_port = k[0];
`else
            exp_port = 1'b0;
`endif
            exp_q.push_back('{exp_port, rd_model(exp_port ? 32'h200 : 32'h100)});
            wait_gnt(12, g);
            check($sformatf("tie_gnt%0d", k), {30'b0, g}, exp_port ? 32'h2 : 32'h1);
        end
        tick();
        bus.req = 2'b00;
        repeat (4) tick();
        check("tie_drain", 32'(exp_q.size()), 32'h0);

        // RD_LAT=1 instance: WAIT skipped, data sampled at the end of ISSUE.
        bus1.req = 2'b01; bus1.addr[0] = 32'h55;
        tick();
        check("l1_gnt", {30'b0, bus1.gnt}, 32'h1);
        check("l1_re", {31'b0, pimre1}, 32'h1);
        tick();
        bus1.req = 2'b00;
        check("l1_rvalid", {30'b0, bus1.rvalid}, 32'h1);
        check("l1_rdata", bus1.rdata, rd_model(32'h55));
        tick();
        check("l1_rvalid_off", {30'b0, bus1.rvalid}, 32'h0);
        check("l1_rdata_hold", bus1.rdata, rd_model(32'h55));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
